// File: rtl/clk_period_meter.sv
// clk_period_meter: single-shot period and high-time measurement of a slow asynchronous square wave.
// Ports: clk/rst_n (async active-low) clock and reset; sig_in signal under test; start begins a measurement;
// busy while measuring; done one-cycle end pulse; timeout valid with done; period/high_time results in clk cycles.
`timescale 1ns/1ps
module clk_period_meter #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time
);
  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEAS_HIGH, MEAS_LOW} state_t;
  state_t state_q, state_d;
  logic s1_q, s2_q, prev_q;
  logic done_q, done_d, to_q, to_d;
  logic rise_p, fall_p, finish, expire;
  logic [CNT_W-1:0] wd_q, wd_d, cnt_q, cnt_d, hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d, high_q, high_d;
  always_comb begin
    rise_p   = s2_q & ~prev_q;
    fall_p   = ~s2_q & prev_q;
    finish   = (state_q == MEAS_LOW) && rise_p;
    expire   = (state_q != IDLE) && (wd_q == CNT_W'(TIMEOUT - 1));
    // a completing edge beats a simultaneous watchdog expiry
    done_d   = finish | expire;
    to_d     = expire & ~finish;
    period_d = finish ? cnt_q : expire ? '0 : period_q;
    high_d   = finish ? hi_q : expire ? '0 : high_q;
    wd_d     = (state_q == IDLE) ? '0 : wd_q + 1'b1;
    // while waiting, cnt is preloaded so that it reads cycles-since-rise once measuring
    cnt_d    = (state_q == IDLE) ? '0 : (state_q == WAIT_RISE) ? CNT_W'(1) : cnt_q + 1'b1;
    hi_d     = (state_q == MEAS_HIGH && fall_p) ? cnt_q : hi_q;
    // start is refused while the done pulse is out, so back-to-back requests need one idle cycle
    state_d  = done_d ? IDLE :
               (state_q == IDLE && start && !done_q) ? WAIT_RISE :
               (state_q == WAIT_RISE && rise_p) ? MEAS_HIGH :
               (state_q == MEAS_HIGH && fall_p) ? MEAS_LOW : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      prev_q   <= 1'b0;
      done_q   <= 1'b0;
      to_q     <= 1'b0;
      wd_q     <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      period_q <= '0;
      high_q   <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= sig_in;
      s2_q     <= s1_q;
      prev_q   <= s2_q;
      done_q   <= done_d;
      to_q     <= to_d;
      wd_q     <= wd_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      period_q <= period_d;
      high_q   <= high_d;
    end
  end
  assign busy      = state_q != IDLE;
  assign done      = done_q;
  assign timeout   = to_q;
  assign period    = period_q;
  assign high_time = high_q;
endmodule

// File: tb/tb_clk_period_meter.sv
// tb_clk_period_meter: randomized scoreboard bench for clk_period_meter.
`timescale 1ns/1ps
module tb_clk_period_meter;
  localparam int CNT_W = 16;
  localparam int TO    = 1000;
  localparam int NW    = 40000;
  typedef struct {int dc; int to; int per; int hi;} exp_t;
  logic clk = 0, rst_n = 0, sig_in = 0, start = 0;
  logic busy, done, timeout;
  logic [CNT_W-1:0] period, high_time;
  int cyc = 0, checks = 0, errors = 0, free_cyc = 0;
  int hold_per = 0, hold_hi = 0;
  bit wave [NW];
  exp_t q[$];
  exp_t mon_e, me;
  clk_period_meter #(.CNT_W(CNT_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .start(start), .busy(busy),
    .done(done), .timeout(timeout), .period(period), .high_time(high_time)
  );
  initial forever begin
    #5 clk = 1;
    cyc++;
    #5 clk = 0;
  end
  always @(posedge clk) begin
    #1;
    sig_in = (cyc < NW) ? wave[cyc] : 1'b0;
  end
  initial begin
    #(NW * 10);
    $display("FAIL global_time_limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask
  function automatic bit rising(input int t);
    return t > 0 && t < NW && !wave[t-1] && wave[t];
  endfunction
  function automatic bit falling(input int t);
    return t > 0 && t < NW && wave[t-1] && !wave[t];
  endfunction
  // sig_in transitions are seen two cycles after they are driven; start in cycle a makes edges
  // driven from cycle a-1 on eligible, and the watchdog allows completions detected by cycle a+TO
  function automatic exp_t model(input int a);
    exp_t e;
    int r1 = -1, f = -1, r2 = -1;
    for (int t = a - 1; t <= a + TO + 4 && r2 < 0; t++) begin
      if (r1 < 0) begin
        if (rising(t)) r1 = t;
      end else if (f < 0) begin
        if (falling(t)) f = t;
      end else if (rising(t)) r2 = t;
    end
    if (r2 >= 0 && r2 + 2 <= a + TO) begin
      e.dc = r2 + 3; e.to = 0; e.per = r2 - r1; e.hi = f - r1;
    end else begin
      e.dc = a + TO + 1; e.to = 1; e.per = 0; e.hi = 0;
    end
    return e;
  endfunction
  task automatic fill(input int from, input int upto, input int p, input int h, input int ph);
    for (int n = from; n <= upto && n < NW; n++) wave[n] = ((n + ph) % p) < h;
  endtask
  task automatic fill0(input int from, input int upto);
    for (int n = from; n <= upto && n < NW; n++) wave[n] = 1'b0;
  endtask
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic issue_start();
    exp_t e;
    start = 1;
    if (cyc >= free_cyc) begin
      e = model(cyc);
      q.push_back(e);
      free_cyc = e.dc + 1;
    end
    step(1);
    start = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (q.size() > 0 && n < TO + 100) begin
      step(1);
      n++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL wait_done at cycle %0d: got no done, expected done by cycle %0d", cyc, q[0].dc);
      q.delete();
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (rst_n) begin
      if (done) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 expected done=0", cyc);
        end else begin
          mon_e = q.pop_front();
          chk("done_cycle", cyc, mon_e.dc);
          chk("timeout", timeout, mon_e.to);
          chk("period", period, mon_e.per);
          chk("high_time", high_time, mon_e.hi);
          chk("busy_at_done", busy, 0);
          hold_per = mon_e.per;
          hold_hi = mon_e.hi;
        end
      end else begin
        chk("period_hold", period, hold_per);
        chk("high_hold", high_time, hold_hi);
        chk("timeout_idle", timeout, 0);
      end
    end
  end
  initial begin
    int c, a, r1, r2, p, h;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    #10 rst_n = 1;
    step(3);
    c = cyc;
    fill(c + 1, c + TO + 50, 10, 4, 0);
    step(4);
    issue_start();
    chk("busy_rise", busy, 1);
    wait_idle();
    chk("busy_after", busy, 0);
    c = cyc;
    a = c + 5;
    fill(c + 1, c + TO + 50, 100, 50, (100 - (a % 100) + 10) % 100);
    step(5);
    issue_start();
    wait_idle();
    c = cyc;
    fill0(c + 1, c + TO + 50);
    step(5);
    issue_start();
    chk("busy_rise_to", busy, 1);
    wait_idle();
    c = cyc;
    fill(c + 1, c + 3000, 50, 20, $urandom_range(0, 49));
    step(5);
    issue_start();
    while (cyc + 6 < free_cyc - 1) begin
      step(6);
      issue_start();
    end
    while (cyc < free_cyc - 1) step(1);
    issue_start();
    issue_start();
    wait_idle();
    c = cyc;
    fill(c + 1, c + TO + 50, 60, 20, $urandom_range(0, 59));
    step(5);
    issue_start();
    me = q[0];
    while (cyc < me.dc - 10) step(1);
    #2 rst_n = 0;
    q.delete();
    free_cyc = 0;
    hold_per = 0;
    hold_hi = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_timeout", timeout, 0);
    chk("arst_period", period, 0);
    chk("arst_high", high_time, 0);
    step(2);
    rst_n = 1;
    step(6);
    c = cyc;
    fill(c + 1, c + TO + 50, 37, 2, $urandom_range(0, 36));
    step(5);
    issue_start();
    wait_idle();
    for (int k = 0; k < 2; k++) begin
      c = cyc;
      a = c + 5;
      r2 = a + TO - 2 + k;
      r1 = r2 - 40;
      fill0(c + 1, c + TO + 60);
      for (int n = 0; n < 15; n++) begin
        wave[r1 + n] = 1'b1;
        wave[r2 + n] = 1'b1;
      end
      step(5);
      issue_start();
      wait_idle();
    end
    repeat (12) begin
      c = cyc;
      p = $urandom_range(4, 700);
      h = $urandom_range(2, p - 2);
      fill(c + 1, c + TO + 60, p, h, $urandom_range(0, p - 1));
      step($urandom_range(3, 8));
      issue_start();
      wait_idle();
    end
    step(3);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
